// File: rtl/spi_pkg.sv
// spi_pkg: command layout, reserved address and sequencer states for spi_txn_sequencer.
package spi_pkg;
  localparam int CMD_W = 12;
  localparam int ADDR_HI = 11;
  localparam int ADDR_LO = 10;
  localparam int CPOL_BIT = 9;
  localparam int CPHA_BIT = 8;
  localparam int TX_HI = 7;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_RESP
  } state_t;
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous FIFO holding queued SPI commands; head visible on dout_o.
module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = mem_q[rd_q];
  // a full FIFO may still accept a write when the head leaves in the same cycle
  assign wr = push_i && (!full_o || pop_i);
  assign rd = pop_i && !empty_o;
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wr_q <= wr_q + AW'(1);
      if (rd) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: queues SPI commands and runs one 8-bit SPI_Protocol transfer at a time.
module spi_txn_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XFER_CYCLES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_addr,
  output logic        rsp_err,
  output logic        busy,
  output logic        load,
  output logic        start,
  output logic [7:0]  data_in_master,
  output logic [1:0]  Address,
  output logic        CPOL,
  output logic        CPHA,
  input  logic [7:0]  data_out_master
);
  localparam int CW = $clog2(XFER_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] dim_q, dim_d, rsp_data_q, rsp_data_d;
  logic [1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, rsp_err_q, rsp_err_d;
  logic [CMD_W-1:0] head;
  logic full, empty, pop;
  assign pop = state_q == S_IDLE && !empty;
  spi_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk), .reset(reset), .push_i(cmd_valid && !full), .pop_i(pop),
    .din_i(cmd_data), .dout_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dim_d = dim_q;
    addr_d = addr_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE:
        if (!empty) begin
          if (head[ADDR_HI:ADDR_LO] == ADDR_INVALID) begin
            state_d = S_RESP;
            rsp_err_d = 1'b1;
            rsp_data_d = '0;
            rsp_addr_d = ADDR_INVALID;
          end else begin
            // SPI configuration is only ever updated here, so SCLK idle level stays put
            state_d = S_LOAD;
            dim_d = head[TX_HI:0];
            addr_d = head[ADDR_HI:ADDR_LO];
            cpol_d = head[CPOL_BIT];
            cpha_d = head[CPHA_BIT];
          end
        end
      S_LOAD: state_d = S_START;
      S_START: begin
        cnt_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(XFER_CYCLES - 1) ? S_CAPTURE : S_WAIT;
      end
      S_CAPTURE: begin
        rsp_data_d = data_out_master;
        rsp_addr_d = addr_q;
        rsp_err_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      dim_q <= '0;
      addr_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dim_q <= dim_d;
      addr_q <= addr_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign cmd_ready = !full;
  assign busy = state_q != S_IDLE || !empty;
  assign load = state_q == S_LOAD;
  assign start = state_q == S_START;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_data = rsp_data_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_err = rsp_err_q;
  assign data_in_master = dim_q;
  assign Address = addr_q;
  assign CPOL = cpol_q;
  assign CPHA = cpha_q;
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: directed vectors and corner sequences against a simple SPI slave model.
module tb_spi_txn_sequencer;
  localparam int XFER = 20;
  logic clk = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [11:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy, load, start, CPOL, CPHA;
  logic [7:0] rsp_data, data_in_master, data_out_master, pend;
  logic [1:0] rsp_addr, Address;
  int n_pass = 0, n_total = 0;
  int scnt;
  logic rs_q = 1'b0, prev_start = 1'b0;
  logic [11:0] prev_cfg = '0;

  spi_txn_sequencer #(.DEPTH(4), .XFER_CYCLES(XFER)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy),
    .load(load), .start(start), .data_in_master(data_in_master), .Address(Address),
    .CPOL(CPOL), .CPHA(CPHA), .data_out_master(data_out_master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // slave: answers tx ^ 8'h99 ^ {cpol,cpha,6'b0}, valid only XFER cycles after start
  always @(posedge clk) begin
    if (!reset) begin
      data_out_master <= '0;
      scnt <= 0;
    end else if (start) begin
      scnt <= XFER;
      pend <= data_in_master ^ 8'h99 ^ {CPOL, CPHA, 6'b0};
      data_out_master <= 8'h5A;
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) data_out_master <= pend;
    end
  end

  always @(posedge clk) rs_q <= reset;

  always @(negedge clk) begin
    if (rs_q && {data_in_master, Address, CPOL, CPHA} != prev_cfg)
      check("cfg_change_in_load", {31'd0, load}, 1);
    if (start) check("start_single_no_load", {30'd0, prev_start, load}, 0);
    prev_cfg <= {data_in_master, Address, CPOL, CPHA};
    prev_start <= start;
  end

  task automatic push(input logic [11:0] c);
    int i;
    cmd_valid = 1'b1;
    cmd_data = c;
    for (i = 0; i < 400 && !cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("push_ready", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [7:0] d, input logic [1:0] a, input logic e);
    int i;
    rsp_ready = 1'b1;
    for (i = 0; i < 400 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("rsp_valid", {31'd0, rsp_valid}, 1);
    check("rsp_data", {24'd0, rsp_data}, {24'd0, d});
    check("rsp_addr", {30'd0, rsp_addr}, {30'd0, a});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e});
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [11:0] cmd;
    logic [7:0] d;
    logic [1:0] a;
    logic e;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int load_k, start_k, rsp_k;
    logic [1:0] addr_at_load;
    logic xfer_seen, rv_seen;
    vecs[0] = '{{2'b01, 1'b0, 1'b0, 8'hA5}, 8'h3C, 2'b01, 1'b0};
    vecs[1] = '{{2'b11, 1'b0, 1'b0, 8'hFF}, 8'h00, 2'b11, 1'b1};
    vecs[2] = '{{2'b10, 1'b0, 1'b0, 8'h00}, 8'h99, 2'b10, 1'b0};
    vecs[3] = '{{2'b00, 1'b1, 1'b1, 8'h12}, 8'h4B, 2'b00, 1'b0};
    vecs[4] = '{{2'b10, 1'b0, 1'b1, 8'hF0}, 8'h29, 2'b10, 1'b0};
    vecs[5] = '{{2'b01, 1'b1, 1'b0, 8'h7E}, 8'h67, 2'b01, 1'b0};
    vecs[6] = '{{2'b11, 1'b1, 1'b1, 8'h33}, 8'h00, 2'b11, 1'b1};
    vecs[7] = '{{2'b00, 1'b0, 1'b0, 8'hFF}, 8'h66, 2'b00, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_spi_out", {18'd0, load, start, data_in_master, Address, CPOL, CPHA}, 0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_rsp_busy", {30'd0, rsp_valid, busy}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", {28'd0, load, start, rsp_valid, busy}, 0);
    // single transfer: exact load/start/response timing
    push({2'b01, 1'b0, 1'b0, 8'hA5});
    load_k = -1; start_k = -1; rsp_k = -1; addr_at_load = '0;
    for (int k = 1; k < 100 && rsp_k < 0; k++) begin
      @(posedge clk);
      #1;
      if (load && load_k < 0) begin load_k = k; addr_at_load = Address; end
      if (start && start_k < 0) start_k = k;
      if (rsp_valid) rsp_k = k;
    end
    check("load_cycle", load_k, 1);
    check("start_cycle", start_k, 2);
    check("rsp_latency", rsp_k, XFER + 4);
    check("addr_at_load", {30'd0, addr_at_load}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rsp_hold", {20'd0, rsp_valid, rsp_err, rsp_addr, rsp_data}, {20'd0, 1'b1, 1'b0, 2'b01, 8'h3C});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("after_handshake", {30'd0, rsp_valid, busy}, 0);
    // rejected address: fast error response, no transfer issued
    push({2'b11, 1'b1, 1'b0, 8'h44});
    rsp_k = -1; xfer_seen = 1'b0;
    for (int k = 1; k < 10 && rsp_k < 0; k++) begin
      if (load || start) xfer_seen = 1'b1;
      if (rsp_valid) rsp_k = k;
      else begin @(posedge clk); #1; end
    end
    check("err_latency_le2", {31'd0, rsp_k >= 1 && rsp_k <= 2}, 1);
    check("err_no_xfer", {31'd0, xfer_seen}, 0);
    check("err_cfg_held", {20'd0, data_in_master, Address, CPOL, CPHA}, {20'd0, 8'hA5, 2'b01, 2'b00});
    get_rsp(8'h00, 2'b11, 1'b1);
    // table of commands, one at a time
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].cmd);
      get_rsp(vecs[i].d, vecs[i].a, vecs[i].e);
    end
    // fill the FIFO behind a response that is not being consumed
    push({2'b00, 1'b0, 1'b0, 8'h01});
    push({2'b01, 1'b0, 1'b0, 8'h02});
    push({2'b10, 1'b0, 1'b0, 8'h03});
    push({2'b00, 1'b1, 1'b0, 8'h04});
    check("ready_before_full", {31'd0, cmd_ready}, 1);
    push({2'b01, 1'b0, 1'b1, 8'h05});
    check("full_not_ready", {30'd0, cmd_ready, busy}, {30'd0, 1'b0, 1'b1});
    get_rsp(8'h98, 2'b00, 1'b0);
    get_rsp(8'h9B, 2'b01, 1'b0);
    get_rsp(8'h9A, 2'b10, 1'b0);
    get_rsp(8'h1D, 2'b00, 1'b0);
    get_rsp(8'hDC, 2'b01, 1'b0);
    check("drained", {30'd0, busy, cmd_ready}, 1);
    // reset in the middle of a transfer with another command queued
    push({2'b01, 1'b1, 1'b1, 8'hA5});
    push({2'b10, 1'b0, 1'b0, 8'h11});
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midrst_spi_out", {18'd0, load, start, data_in_master, Address, CPOL, CPHA}, 0);
    check("midrst_status", {29'd0, rsp_valid, busy, cmd_ready}, 1);
    rv_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy || load || start) rv_seen = 1'b1;
    end
    check("midrst_no_rsp", {31'd0, rv_seen}, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
